// File: rtl/clz_normalizer.sv
// clz_normalizer: multi-cycle leading-bit counter / normalizer.
// Binary search over shift widths 16,8,4,2,1 (one per cycle), then a final
// single-bit fix-up. Result registers update only on the FIX edge.
module clz_normalizer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [1:0]  op,
  output logic        busy,
  output logic        done,
  output logic [5:0]  count,
  output logic [31:0] r,
  output logic        zero,
  output logic        negative
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [31:0] w_q, w_d;
  logic [5:0]  c_q, c_d;
  logic        tgt_q, tgt_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] r_q, r_d;
  logic        zero_q, zero_d;
  logic        neg_q, neg_d;

  // Search-step helpers: current width, its top-bit mask, and the match test.
  logic [4:0]  sw;
  logic [31:0] top_mask;
  logic        top_match;
  logic [31:0] w_fix;
  logic [5:0]  c_fix;

  // Width schedule and the "top w bits all equal target" test.
  always_comb begin
    sw = 5'd1;
    case (step_q)
      3'd0:    sw = 5'd16;
      3'd1:    sw = 5'd8;
      3'd2:    sw = 5'd4;
      3'd3:    sw = 5'd2;
      default: sw = 5'd1;
    endcase
    top_mask  = ~(32'hFFFF_FFFF >> sw);
    top_match = (((w_q ^ {32{tgt_q}}) & top_mask) == 32'd0);
    // Final single-bit step: covers the 32nd matching bit (all-match operands).
    w_fix = w_q;
    c_fix = c_q;
    if (w_q[31] == tgt_q) begin
      w_fix = w_q << 1;
      c_fix = c_q + 6'd1;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    w_d     = w_q;
    c_d     = c_q;
    tgt_d   = tgt_q;
    count_d = count_q;
    r_d     = r_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_d     = a;
          c_d     = 6'd0;
          step_d  = 3'd0;
          // op 11 is reserved and falls through to CLZ (target 0).
          tgt_d   = (op == 2'b01) ? 1'b1 : (op == 2'b10) ? a[31] : 1'b0;
          state_d = S_SEARCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEARCH: begin
        if (top_match) begin
          w_d = w_q << sw;
          c_d = c_q + {1'b0, sw};
        end
        if (step_q == 3'd4) state_d = S_FIX;
        else                step_d  = step_q + 3'd1;
      end
      S_FIX: begin
        w_d     = w_fix;
        c_d     = c_fix;
        count_d = c_fix;
        r_d     = w_fix;
        zero_d  = (w_fix == 32'd0);
        neg_d   = w_fix[31];
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset wins over start and aborts a search.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= 3'd0;
      w_q     <= 32'd0;
      c_q     <= 6'd0;
      tgt_q   <= 1'b0;
      count_q <= 6'd0;
      r_q     <= 32'd0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      w_q     <= w_d;
      c_q     <= c_d;
      tgt_q   <= tgt_d;
      count_q <= count_d;
      r_q     <= r_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign busy     = (state_q == S_SEARCH) || (state_q == S_FIX);
  assign done     = (state_q == S_DONE);
  assign count    = count_q;
  assign r        = r_q;
  assign zero     = zero_q;
  assign negative = neg_q;

endmodule

// File: tb/tb_clz_normalizer.sv
// Directed bench for clz_normalizer: inputs driven and outputs sampled on
// the falling edge, so everything is observed half a cycle after each edge.
module tb_clz_normalizer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] a;
  logic [1:0]  op;
  logic        busy, done, zero, negative;
  logic [5:0]  count;
  logic [31:0] r;

  int vectors = 0;
  int miscompares = 0;

  clz_normalizer dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .op(op),
    .busy(busy), .done(done), .count(count), .r(r),
    .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  // Pulse start for one cycle and wait (bounded) for done.
  // lat = falling edges from the start edge to the done cycle; bsy = busy cycles.
  task automatic run(input logic [31:0] av, input logic [1:0] opv,
                     output int lat, output int bsy);
    @(negedge clk);
    a = av; op = opv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; bsy = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bsy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = 32'h0; op = 2'b00;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, count, r, zero, negative} !== {1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b count=%0d r=%h zero=%b neg=%b, want 0 0 0 0 1 0",
               busy, done, count, r, zero, negative);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bsy;
    run(32'h0001_0000, 2'b00, lat, bsy);
    vectors++;
    if (bsy !== 6) begin miscompares++; $display("FAIL basic_busy: got %0d cycles, want 6", bsy); end
    vectors++;
    if (lat !== 7) begin miscompares++; $display("FAIL basic_latency: got %0d, want 7", lat); end
    vectors++;
    if ({count, r, zero, negative} !== {6'd15, 32'h8000_0000, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL basic_result: count=%0d r=%h z=%b n=%b, want 15 80000000 0 1",
               count, r, zero, negative);
    end
  endtask

  // Table of operand/op pairs with hand-computed results.
  task automatic test_table();
    logic [31:0] ta [10];
    logic [1:0]  to [10];
    logic [5:0]  tc [10];
    logic [31:0] tr [10];
    int lat, bsy;
    ta[0] = 32'h0000_0000; to[0] = 2'b00; tc[0] = 6'd32; tr[0] = 32'h0000_0000;
    ta[1] = 32'hFFFF_FFFF; to[1] = 2'b01; tc[1] = 6'd32; tr[1] = 32'h0000_0000;
    ta[2] = 32'h0000_0001; to[2] = 2'b00; tc[2] = 6'd31; tr[2] = 32'h8000_0000;
    ta[3] = 32'hF800_0001; to[3] = 2'b01; tc[3] = 6'd5;  tr[3] = 32'h0000_0020;
    ta[4] = 32'h00FF_0000; to[4] = 2'b10; tc[4] = 6'd8;  tr[4] = 32'hFF00_0000;
    ta[5] = 32'h00FF_0000; to[5] = 2'b11; tc[5] = 6'd8;  tr[5] = 32'hFF00_0000;
    ta[6] = 32'h0000_0000; to[6] = 2'b10; tc[6] = 6'd32; tr[6] = 32'h0000_0000;
    ta[7] = 32'hFFFF_FFFF; to[7] = 2'b10; tc[7] = 6'd32; tr[7] = 32'h0000_0000;
    ta[8] = 32'h8000_0000; to[8] = 2'b00; tc[8] = 6'd0;  tr[8] = 32'h8000_0000;
    ta[9] = 32'hFFFE_1234; to[9] = 2'b10; tc[9] = 6'd15; tr[9] = 32'h091A_0000;
    for (int i = 0; i < 10; i++) begin
      run(ta[i], to[i], lat, bsy);
      vectors++;
      if (lat !== 7 || count !== tc[i] || r !== tr[i] ||
          zero !== (tr[i] == 32'd0) || negative !== tr[i][31]) begin
        miscompares++;
        $display("FAIL table[%0d] a=%h op=%b: lat=%0d count=%0d r=%h z=%b n=%b, want 7 %0d %h %b %b",
                 i, ta[i], to[i], lat, count, r, zero, negative,
                 tc[i], tr[i], (tr[i] == 32'd0), tr[i][31]);
      end
    end
  endtask

  // Results hold through IDLE, and done is a single-cycle pulse.
  task automatic test_hold();
    int lat, bsy;
    run(32'h0000_0100, 2'b00, lat, bsy);
    repeat (3) @(negedge clk);
    vectors++;
    if ({done, busy, count, r} !== {1'b0, 1'b0, 6'd23, 32'h8000_0000}) begin
      miscompares++;
      $display("FAIL hold: done=%b busy=%b count=%0d r=%h, want 0 0 23 80000000", done, busy, count, r);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bsy;
    run(32'h0001_0000, 2'b00, lat, bsy);
    // Now sitting in the DONE cycle: issue the next request immediately.
    a = 32'h4000_0000; op = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      if (lat == 3) begin a = 32'h0000_0001; op = 2'b01; start = 1'b1; end
      else          start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    vectors++;
    if (lat !== 7) begin miscompares++; $display("FAIL b2b_latency: got %0d, want 7", lat); end
    vectors++;
    if ({count, r, zero, negative} !== {6'd1, 32'h8000_0000, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_result: count=%0d r=%h z=%b n=%b, want 1 80000000 0 1", count, r, zero, negative);
    end
    @(negedge clk);
    vectors++;
    if ({done, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_idle: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bsy, seen;
    @(negedge clk);
    a = 32'h0001_0000; op = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;            // busy cycle 1
    repeat (2) @(negedge clk); // busy cycle 3
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, done, count, r, zero, negative} !== {1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b done=%b count=%0d r=%h z=%b n=%b, want 0 0 0 0 1 0",
               busy, done, count, r, zero, negative);
    end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      @(negedge clk);
    end
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL reset_mid_quiet: %0d active cycles, want 0", seen); end
    run(32'h0000_0400, 2'b00, lat, bsy);
    vectors++;
    if (lat !== 7 || count !== 6'd21 || r !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL reset_mid_after: lat=%0d count=%0d r=%h, want 7 21 80000000", lat, count, r);
    end
  endtask

  task automatic test_reset_start();
    @(negedge clk);
    reset = 1'b1; start = 1'b1; a = 32'h0000_0001; op = 2'b00;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    vectors++;
    if ({busy, done, count} !== {1'b0, 1'b0, 6'd0}) begin
      miscompares++;
      $display("FAIL reset_start: busy=%b done=%b count=%0d, want 0 0 0", busy, done, count);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_start_idle: busy=%b, want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_table();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_reset_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
